accel_spi_reader: RTL and testbench
===================================

// Module: accel_spi_reader
// PURPOSE
//  SPI master that polls a 3-axis accelerometer (ADXL345 register map, SPI mode 3)
//  and converts the X/Y samples to signed 8-bit accelerations. Sits directly upstream
//  of the ball positioner: o_accel_x/o_accel_y drive its i_accel_x/i_accel_y.
//  Also performs a one-shot sensor power-up write after reset.
// PARAMETERS
//  CLK_DIV      4       clk cycles per SCLK half-period (>=2)
//  POLL_PERIOD  100000  clk cycles between starts of consecutive X/Y read bursts
//  SHIFT        2       arithmetic right shift applied to raw 16-bit sample (0..8)
//  DEADZONE     2       |value| threshold zeroed when ACCEL_DEADZONE_EN is defined
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset; synchronous, active-high
//  i_spi_miso  in   1  sensor SDO
//  o_spi_sclk  out  1  SPI clock; idles high
//  o_spi_cs_n  out  1  chip select, active-low
//  o_spi_mosi  out  1  sensor SDI
//  o_accel_x   out  8  signed X acceleration (two's complement)
//  o_accel_y   out  8  signed Y acceleration (two's complement)
//  o_valid     out  1  one-cycle pulse when o_accel_x/y update
//  o_busy      out  1  high while CS_n asserted
// BEHAVIOUR
//  - Reset values: sclk=1, cs_n=1, mosi=0, accel_x/y=0, valid=0, busy=0; FSM->INIT.
//    rst mid-transfer aborts immediately (next edge): cs_n/sclk high, init rerun.
//  - FSM: INIT -> INIT_GAP -> IDLE -> READ -> UPDATE -> IDLE.
//    INIT: 16-bit write 0x2D,0x08 (POWER_CTL measure). INIT_GAP: cs_n high
//    2*CLK_DIV cycles. IDLE: wait poll counter. READ: 40-bit burst, cmd 0xF2
//    (R=1, MB=1, addr 0x32) then 4 bytes X0,X1,Y0,Y1. UPDATE: 1 cycle, regs load.
//  - SPI timing (mode 3, MSB first): cs_n falls; CLK_DIV cycles later first sclk
//    fall. MOSI changes on sclk falling edge; MISO sampled on sclk rising edge.
//    After last rising edge hold CLK_DIV cycles, then cs_n rises. mosi=0 in data bytes.
//  - cs_n high for >=2*CLK_DIV cycles between any two transactions.
//  - Poll counter restarts when READ begins (start-to-start period). If a burst
//    plus min gap exceeds POLL_PERIOD, next READ starts right after the min gap;
//    no ticks are queued. First READ starts immediately after INIT_GAP.
//  - Conversion per axis: raw = {byte1,byte0} signed 16-bit; s = raw >>> SHIFT;
//    saturate s to [-128,127]; result registered in UPDATE, o_valid=1 that cycle.
//    X and Y always update together; outputs hold between updates.
//  - o_busy = ~o_spi_cs_n (registered, same cycle as cs_n).
// CONFIGURATION
//  ACCEL_DEADZONE_EN defined: after saturation, any value with |v| <= DEADZONE
//    is output as 0 (e.g. +/-2 -> 0, 3 -> 3). Not defined: no deadzone, DEADZONE
//    parameter unused; saturated value output directly.
// TESTING  (SPI slave model, CLK_DIV=4, POLL_PERIOD=2000, SHIFT=2)
//  - Reset release -> 16 sclk cycles shifting 0x2D,0x08 on MOSI; cs_n high >=8 clk;
//    then READ with MOSI 0xF2 in first byte, 40 sclk rising edges total.
//  - Slave returns X=0x0064 (100), Y=0xFF9C (-100) -> accel_x=25 (0x19),
//    accel_y=-25 (0xE7), o_valid one cycle, values stable until next update.
//  - X=0x7FFF, Y=0x8000 -> accel_x=127 (0x7F), accel_y=-128 (0x80) (saturation).
//  - Measure cs_n falling edges of successive READs -> exactly 2000 clk apart;
//    with POLL_PERIOD=100 -> gap between reads equals 8 clk minimum, no extra burst.
//  - Assert rst at bit 20 of READ -> next edge cs_n=1, sclk=1, accel=0, valid=0;
//    after release INIT write repeats before any READ.
//  - ACCEL_DEADZONE_EN, X=0x0008 (->2), Y=0x000C (->3) -> accel_x=0, accel_y=3;
//    without macro -> accel_x=2, accel_y=3.

Source files
------------

// File: rtl/accel_spi_reader.sv
// SPI mode-3 master that powers up an ADXL345, then polls X/Y and saturates them to signed 8 bits.
// Optional output deadzone is compiled in when ACCEL_DEADZONE_EN is defined.
module accel_spi_reader #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_PERIOD = 100000,
    parameter int SHIFT       = 2,
    parameter int DEADZONE    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_spi_miso,
    output logic       o_spi_sclk,
    output logic       o_spi_cs_n,
    output logic       o_spi_mosi,
    output logic [7:0] o_accel_x,
    output logic [7:0] o_accel_y,
    output logic       o_valid,
    output logic       o_busy
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(2 * CLK_DIV + 1);
    localparam int PW = $clog2(POLL_PERIOD + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {S_INIT, S_INIT_GAP, S_IDLE, S_READ, S_UPDATE} state_t;

    state_t        state_r, next_state_s;
    logic [DW-1:0] div_cnt_r;
    logic [6:0]    half_r;      // 0 = CS setup, odd = SCLK low, even = SCLK high
    logic [GW-1:0] gap_cnt_r;
    logic [PW-1:0] poll_cnt_r;
    logic [31:0]   rx_r;
    logic          xfer_s, xfer_done_s, gap_ok_s, poll_due_s;
    logic          sclk_s, cs_n_s, mosi_s, sample_s;
    logic [6:0]    last_half_s;
    logic [5:0]    bit_idx_s;
    logic [39:0]   tx_word_s;

    function automatic logic [7:0] to_accel(input logic [15:0] raw);
        logic signed [15:0] s;
        logic [7:0]         v;
        int                 vi;
        s = $signed(raw) >>> SHIFT;
        if (s > 16'sd127) begin
            v = 8'h7F;
        end else if (s < -16'sd128) begin
            v = 8'h80;
        end else begin
            v = s[7:0];
        end
`ifdef ACCEL_DEADZONE_EN
        vi = int'($signed(v));
        if (vi >= -DEADZONE && vi <= DEADZONE) begin
            v = 8'h00;
        end else begin
            v = v;
        end
`else
        vi = 0;
`endif
        return v;
    endfunction

    assign xfer_s      = (state_r == S_INIT) || (state_r == S_READ);
    assign last_half_s = (state_r == S_READ) ? 7'd80 : 7'd32;
    assign xfer_done_s = xfer_s && (div_cnt_r == DIV_LAST) && (half_r == last_half_s);
    assign gap_ok_s    = (gap_cnt_r >= GAP_LAST);
    assign poll_due_s  = (poll_cnt_r >= POLL_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_INIT:     if (xfer_done_s) next_state_s = S_INIT_GAP; else next_state_s = S_INIT;
            S_INIT_GAP: if (gap_ok_s) next_state_s = S_READ; else next_state_s = S_INIT_GAP;
            S_IDLE:     if (gap_ok_s && poll_due_s) next_state_s = S_READ; else next_state_s = S_IDLE;
            S_READ:     if (xfer_done_s) next_state_s = S_UPDATE; else next_state_s = S_READ;
            S_UPDATE:   next_state_s = S_IDLE;
            default:    next_state_s = S_INIT;
        endcase
    end

    // Pin values for the next cycle; every pin lags the state by one register stage
    always_comb begin
        tx_word_s = (state_r == S_READ) ? {8'hF2, 32'h0000_0000} : {8'h2D, 8'h08, 24'h00_0000};
        bit_idx_s = 6'((half_r - 7'd1) >> 1);
        cs_n_s    = ~xfer_s;
        sclk_s    = ~(xfer_s && half_r[0]);
        if (xfer_s && (half_r != 7'd0)) begin
            mosi_s = tx_word_s[6'd39 - bit_idx_s];
        end else begin
            mosi_s = 1'b0;
        end
        sample_s = (state_r == S_READ) && (half_r != 7'd0) && !half_r[0] && (div_cnt_r == '0);
    end

    // SCLK half-period timing within a transfer
    always_ff @(posedge clk) begin
        if (rst || !xfer_s || (next_state_s != state_r)) begin
            div_cnt_r <= '0;
            half_r    <= 7'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            half_r    <= half_r + 7'd1;
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
            half_r    <= half_r;
        end
    end

    // CS-high gap and start-to-start poll counters (both saturate, so no ticks queue up)
    always_ff @(posedge clk) begin
        if (rst || xfer_s) begin
            gap_cnt_r <= '0;
        end else if (!gap_ok_s) begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
        if (rst || ((next_state_s == S_READ) && (state_r != S_READ))) begin
            poll_cnt_r <= '0;
        end else if (!poll_due_s) begin
            poll_cnt_r <= poll_cnt_r + PW'(1);
        end else begin
            poll_cnt_r <= poll_cnt_r;
        end
    end

    // MISO capture on SCLK rising edges; the command byte falls off the top
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_r <= 32'h0000_0000;
        end else if (sample_s) begin
            rx_r <= {rx_r[30:0], i_spi_miso};
        end else begin
            rx_r <= rx_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            o_spi_sclk <= 1'b1;
            o_spi_cs_n <= 1'b1;
            o_spi_mosi <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_accel_x  <= 8'h00;
            o_accel_y  <= 8'h00;
        end else begin
            o_spi_sclk <= sclk_s;
            o_spi_cs_n <= cs_n_s;
            o_spi_mosi <= mosi_s;
            o_busy     <= ~cs_n_s;
            o_valid    <= (state_r == S_UPDATE);
            if (state_r == S_UPDATE) begin
                o_accel_x <= to_accel({rx_r[23:16], rx_r[31:24]});
                o_accel_y <= to_accel({rx_r[7:0], rx_r[15:8]});
            end else begin
                o_accel_x <= o_accel_x;
                o_accel_y <= o_accel_y;
            end
        end
    end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Directed bench for accel_spi_reader with a clock-sampled ADXL345 slave model;
// a second instance with a short poll period checks back-to-back burst spacing.
module tb_accel_spi_reader;
    logic       clk = 1'b0;
    logic       rst;
    logic       miso = 1'b0;
    logic       sclk, cs_n, mosi, valid, busy;
    logic [7:0] accel_x, accel_y;
    logic       f_sclk, f_cs_n, f_mosi, f_valid, f_busy;
    logic [7:0] f_accel_x, f_accel_y;
    logic [15:0] slv_x, slv_y;

    int vec_cnt = 0;
    int err_cnt = 0;

`ifdef ACCEL_DEADZONE_EN
    localparam logic [7:0] DZ_X_EXP = 8'h00;
`else
    localparam logic [7:0] DZ_X_EXP = 8'h02;
`endif

    always #5 clk = ~clk;

    accel_spi_reader #(.CLK_DIV(4), .POLL_PERIOD(2000), .SHIFT(2), .DEADZONE(2)) u_dut (
        .clk(clk), .rst(rst), .i_spi_miso(miso), .o_spi_sclk(sclk), .o_spi_cs_n(cs_n),
        .o_spi_mosi(mosi), .o_accel_x(accel_x), .o_accel_y(accel_y), .o_valid(valid), .o_busy(busy)
    );

    accel_spi_reader #(.CLK_DIV(4), .POLL_PERIOD(100), .SHIFT(2), .DEADZONE(2)) u_dut_fast (
        .clk(clk), .rst(rst), .i_spi_miso(1'b0), .o_spi_sclk(f_sclk), .o_spi_cs_n(f_cs_n),
        .o_spi_mosi(f_mosi), .o_accel_x(f_accel_x), .o_accel_y(f_accel_y), .o_valid(f_valid),
        .o_busy(f_busy)
    );

    // slave model and timing monitor state
    int          cyc = 0;
    logic        sclk_q = 1'b1, cs_q = 1'b1, f_cs_q = 1'b1;
    int          fc = 0, rc = 0, done_cnt = 0, fall_idx = 0, rise_cyc = 0, last_rc = 0;
    logic [39:0] cap = '0, last_cap = '0, sl_tx = '0;
    int          fall_cyc [16];
    int          gap_at [16];
    int          f_fall = 0, f_period = 0, f_rise = 0, f_gap = 0;

    // Slave: drive MISO after SCLK falls, capture MOSI on SCLK rise; record CS timing
    always @(negedge clk) begin
        cyc++;
        if (cs_q && !cs_n) begin
            sl_tx = {8'h00, slv_x[7:0], slv_x[15:8], slv_y[7:0], slv_y[15:8]};
            fc = 0;
            rc = 0;
            cap = '0;
            if (fall_idx < 16) begin
                fall_cyc[fall_idx] = cyc;
                gap_at[fall_idx] = cyc - rise_cyc;
            end
            fall_idx++;
        end
        if (!cs_q && cs_n) begin
            done_cnt++;
            last_rc = rc;
            last_cap = cap;
            rise_cyc = cyc;
        end
        if (!cs_n && sclk_q && !sclk) begin
            if (fc < 40) miso = sl_tx[39 - fc];
            fc++;
        end
        if (!cs_n && !sclk_q && sclk) begin
            cap = {cap[38:0], mosi};
            rc++;
        end
        sclk_q = sclk;
        cs_q = cs_n;
        if (f_cs_q && !f_cs_n) begin
            f_period = cyc - f_fall;
            f_fall = cyc;
            f_gap = cyc - f_rise;
        end
        if (!f_cs_q && f_cs_n) f_rise = cyc;
        f_cs_q = f_cs_n;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int t;
        t = 0;
        while (!valid && t < 4000) begin
            tick();
            t++;
        end
        check_val(tag, valid, 1'b1);
    endtask

    initial begin
        int t;
        int n;
        rst = 1'b1;
        slv_x = 16'h0064;
        slv_y = 16'hFF9C;
        repeat (4) tick();
        check_val("rst_sclk", sclk, 1'b1);
        check_val("rst_cs_n", cs_n, 1'b1);
        check_val("rst_mosi", mosi, 1'b0);
        check_val("rst_x", accel_x, 8'h00);
        check_val("rst_y", accel_y, 8'h00);
        check_val("rst_valid", valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        rst = 1'b0;

        t = 0;
        while (done_cnt < 1 && t < 2000) begin
            tick();
            t++;
        end
        check_val("init_done", done_cnt, 32'd1);
        check_val("init_edges", last_rc, 32'd16);
        check_val("init_mosi", last_cap[15:0], 16'h2D08);

        wait_valid("rd1_valid");
        check_val("rd1_edges", last_rc, 32'd40);
        check_val("rd1_cmd", last_cap[39:32], 8'hF2);
        check_val("rd1_mosi_data", last_cap[31:0], 32'h0);
        check_val("init_gap", gap_at[1], 32'd8);
        check_val("rd1_x", accel_x, 8'h19);
        check_val("rd1_y", accel_y, 8'hE7);
        slv_x = 16'h7FFF;
        slv_y = 16'h8000;
        tick();
        check_val("rd1_pulse", valid, 1'b0);
        check_val("rd1_busy", busy, 1'b0);
        repeat (1000) tick();
        check_val("hold_x", accel_x, 8'h19);
        check_val("hold_y", accel_y, 8'hE7);

        wait_valid("rd2_valid");
        check_val("sat_x", accel_x, 8'h7F);
        check_val("sat_y", accel_y, 8'h80);
        check_val("poll_period", fall_cyc[2] - fall_cyc[1], 32'd2000);
        slv_x = 16'h0008;
        slv_y = 16'h000C;
        tick();

        wait_valid("rd3_valid");
        check_val("dz_x", accel_x, DZ_X_EXP);
        check_val("dz_y", accel_y, 8'h03);

        t = 0;
        while (!(!cs_n && rc == 20) && t < 4000) begin
            tick();
            t++;
        end
        check_val("abort_bit", rc, 32'd20);
        check_val("abort_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check_val("abort_cs_n", cs_n, 1'b1);
        check_val("abort_sclk", sclk, 1'b1);
        check_val("abort_x", accel_x, 8'h00);
        check_val("abort_y", accel_y, 8'h00);
        check_val("abort_valid", valid, 1'b0);
        check_val("abort_busy_off", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        n = done_cnt;
        t = 0;
        while (done_cnt == n && t < 2000) begin
            tick();
            t++;
        end
        check_val("reinit_done", done_cnt - n, 32'd1);
        check_val("reinit_edges", last_rc, 32'd16);
        check_val("reinit_mosi", last_cap[15:0], 16'h2D08);

        repeat (700) tick();
        check_val("fast_period", f_period, 32'd332);
        check_val("fast_gap", f_gap, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
